mem_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares the single-port synchronous `cpumemory` between the CPU core (port 0) and a loader/debug DMA master (port 1). It latches one request at a time, drives the memory's `mw`/`addr`/`data_in` for exactly one cycle, captures `data_out`, and returns a registered response with a fixed latency. It also blocks out-of-range writes so a stray address can never corrupt the 2 KiB table.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port cpumemory.
// One transaction at a time: IDLE -> ISSUE -> RESP -> DONE, fixed 3-cycle latency.

package common_types;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mw_t;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module mem_arbiter
  import common_types::*;
#(
  parameter int unsigned DEPTH = 2048
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req0,
  input  logic  req1,
  input  mw_t   mw0,
  input  mw_t   mw1,
  input  addr_t addr0,
  input  addr_t addr1,
  input  data_t wdata0,
  input  data_t wdata1,
  output logic  ack0,
  output logic  ack1,
  output logic  err0,
  output logic  err1,
  output data_t rdata0,
  output data_t rdata1,
  output mw_t   mem_mw,
  output addr_t mem_addr,
  output data_t mem_wdata,
  input  data_t mem_rdata,
  output logic  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t state;
  mw_t    lat_mw;
  logic   lat_port;
  logic   lat_oor;
  logic   last;

  logic   grant_c;
  mw_t    sel_mw_c;
  addr_t  sel_addr_c;
  data_t  sel_wdata_c;
  logic   sel_oor_c;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign grant_c     = req1 & (~req0 | ~last);
  assign sel_mw_c    = grant_c ? mw1    : mw0;
  assign sel_addr_c  = grant_c ? addr1  : addr0;
  assign sel_wdata_c = grant_c ? wdata1 : wdata0;
  assign sel_oor_c   = 32'(sel_addr_c) >= DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_mw    <= READ;
      lat_port  <= 1'b0;
      lat_oor   <= 1'b0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= 8'h00;
      rdata1    <= 8'h00;
      mem_mw    <= READ;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            lat_port  <= grant_c;
            last      <= grant_c;
            lat_mw    <= sel_mw_c;
            lat_oor   <= sel_oor_c;
            mem_addr  <= sel_addr_c;
            mem_wdata <= sel_wdata_c;
            // Out-of-range writes are presented to the memory as reads.
            mem_mw    <= (sel_mw_c == WRITE && !sel_oor_c) ? WRITE : READ;
          end
        end
        ISSUE: begin
          state  <= RESP;
          mem_mw <= READ;
        end
        RESP: begin
          state <= DONE;
          if (lat_mw == READ && !lat_oor) begin
            if (lat_port) rdata1 <= mem_rdata;
            else          rdata0 <= mem_rdata;
          end
          if (lat_port) begin
            ack1 <= 1'b1;
            err1 <= lat_oor;
          end else begin
            ack0 <= 1'b1;
            err0 <= lat_oor;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
